mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the MEM-stage data port.
- Sequences the accesses one at a time, data port first, then instruction port.
- Generates the IM_stall / DM_stall inputs of the CPU.
- Holds each read result until the pipeline advances.

Parameters:
ADDR_W, 14, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
LAT, 2, cycles per SRAM access (>=1); read data is valid on mem_do during the last access cycle.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
im_req  input  1  instruction fetch request.
im_addr  input  32  fetch byte address (PC).
im_rdata  output  32  fetched instruction, held until advance.
im_stall  output  1  fetch not yet served.
dm_read  input  1  data load request.
dm_write  input  1  data store request.
dm_addr  input  32  data byte address.
dm_web  input  4  active-low byte write enables; 4'b1111 means none.
dm_wdata  input  32  store data, already lane-aligned.
dm_rdata  output  32  load data, held until advance.
dm_stall  output  1  data access not yet served.
mem_cs  output  1  SRAM chip select.
mem_web  output  4  SRAM active-low byte write enables.
mem_addr  output  ADDR_W  SRAM word address.
mem_di  output  32  SRAM write data.
mem_do  input  32  SRAM read data.

Behaviour:
- Reset (async, any time, including mid-access):
  - state = S_IDLE, cnt = 0, im_done = dm_done = 0.
  - im_rdata = dm_rdata = 0, mem_cs = 0, mem_web = 4'b1111, mem_addr = 0, mem_di = 0.
  - Stalls are combinational from requests, so they follow im_req / dm_req as soon as reset deasserts.
- Request and stall definitions:
  - dm_req = dm_read | dm_write.
  - im_stall = im_req & ~im_done.
  - dm_stall = dm_req & ~dm_done.
  - Both stalls are combinational, so they are high in the same cycle a request first appears.
- Advance cycle: any cycle with im_stall = 0 and dm_stall = 0. At the end of an advance cycle, im_done and dm_done clear.
- Requesters hold their request inputs stable while either stall is high. The arbiter does not check this.
- States:
  - S_IDLE:
    - If dm_req & ~dm_done: go to S_DM.
    - Else if im_req & ~im_done: go to S_IM.
    - Else stay.
    - cnt <= 0 on any transition.
  - S_DM / S_IM:
    - mem_cs = 1. mem_addr = owner addr[ADDR_W+1:2].
    - S_DM: mem_web = dm_web if dm_write else 4'b1111; mem_di = dm_wdata.
    - S_IM: mem_web = 4'b1111; mem_di = 0.
    - These outputs are held for all LAT cycles. cnt increments each cycle.
    - At the edge where cnt == LAT-1:
      - Capture mem_do into the owner's rdata register (loads and fetches only; a store leaves dm_rdata unchanged).
      - Set the owner's done flag.
      - Next state: S_IM if in S_DM and im_req & ~im_done; otherwise S_IDLE.
  - In S_IDLE: mem_cs = 0, mem_web = 4'b1111.
- Priority: data over instruction. The older instruction is completed first, so there is no starvation; im is always served within the same advance window.
- Timing:
  - Both requests at cycle 0 (state S_IDLE):
    - cycle 1..LAT: DM access.
    - cycle LAT+1..2*LAT: IM access.
    - cycle 2*LAT+1: both stalls low (advance).
  - Single request: LAT+2 cycles per advance.
- No re-issue: a done flag blocks re-arbitration of the same, still-asserted request during the advance cycle.
- A request that rises while the other access is in flight is queued: its stall is high immediately, and it is served after the in-flight access.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.
- Simultaneous dm_read & dm_write is treated as a write.

Decomposition:
- Package mem_arb_pkg: state enum {S_IDLE, S_DM, S_IM}; constant WEB_NONE = 4'b1111.
- Single module. No sub-module is natural; the latency counter is a few lines inline.

Test Plan:
- Reset, then im_req=1, im_addr=0x0000_0008, mem_do=0x0010_0093 (LAT=2):
  - mem_cs=1, mem_addr=2 in cycles 1-2.
  - im_stall high in cycles 0-2, low in cycle 3.
  - im_rdata=0x0010_0093 from cycle 3.
- Both requests at cycle 0: dm_read addr 0x40 (mem_do 0xDEAD_BEEF), im addr 0x4 (mem_do 0x0000_0013):
  - mem_addr=16 in cycles 1-2, mem_addr=1 in cycles 3-4.
  - Both stalls low in cycle 5; dm_rdata=0xDEAD_BEEF, im_rdata=0x0000_0013.
  - No new access starts in cycle 5.
- dm_write addr 0x10, dm_web=4'b1100, dm_wdata=0x0000_BEEF:
  - mem_addr=4, mem_web=4'b1100, mem_di=0x0000_BEEF in cycles 1-2.
  - dm_rdata unchanged.
- Back-to-back advances with im_req held high and im_addr 0x0, 0x4, 0x8:
  - Each fetch is served exactly once.
  - Advance cycles at 3, 7, 11.
- rst asserted mid-access (cycle 2 of S_DM):
  - Immediately mem_cs=0, mem_web=4'b1111, rdata=0, done flags cleared.
  - After release, the access restarts from S_IDLE.
- LAT=1 build with both requests: DM in cycle 1, IM in cycle 2, advance in cycle 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DM   = 2'd1,
    S_IM   = 2'd2
  } state_t;

  localparam logic [3:0] WEB_NONE = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port SRAM between the fetch port and the data port,
// serving data first and holding each read result until the pipeline advances.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [31:0]       im_addr,
  output logic [31:0]       im_rdata,
  output logic              im_stall,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [31:0]       dm_addr,
  input  logic [3:0]        dm_web,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_stall,
  output logic              mem_cs,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             im_done, dm_done;
  logic             dm_req, dm_pend, im_pend;
  logic             advance, last;

  assign dm_req   = dm_read | dm_write;
  assign dm_pend  = dm_req & ~dm_done;
  assign im_pend  = im_req & ~im_done;
  assign im_stall = im_pend;
  assign dm_stall = dm_pend;
  assign advance  = ~im_pend & ~dm_pend;
  assign last     = (state != S_IDLE) && (cnt == CNT_LAST);

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr[1:0], im_addr[31:ADDR_W+2],
                              dm_addr[1:0], dm_addr[31:ADDR_W+2]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (dm_pend)      state_nxt = S_DM;
        else if (im_pend) state_nxt = S_IM;
      end
      S_DM: begin
        if (last) state_nxt = im_pend ? S_IM : S_IDLE;
      end
      S_IM: begin
        if (last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // SRAM controls are decoded from the state so reset forces them idle at once.
  always_comb begin
    mem_cs   = 1'b0;
    mem_web  = WEB_NONE;
    mem_addr = '0;
    mem_di   = '0;
    case (state)
      S_DM: begin
        mem_cs   = 1'b1;
        mem_addr = dm_addr[ADDR_W+1:2];
        mem_web  = dm_write ? dm_web : WEB_NONE;
        mem_di   = dm_wdata;
      end
      S_IM: begin
        mem_cs   = 1'b1;
        mem_addr = im_addr[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (state != S_IDLE) cnt <= cnt + 1'b1;
    end
  end

  // Done flags block re-arbitration of a still-asserted request until advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_done  <= 1'b0;
      dm_done  <= 1'b0;
      im_rdata <= '0;
      dm_rdata <= '0;
    end else if (advance) begin
      im_done <= 1'b0;
      dm_done <= 1'b0;
    end else if (last) begin
      if (state == S_DM) begin
        dm_done <= 1'b1;
        if (!dm_write) dm_rdata <= mem_do;
      end else begin
        im_done  <= 1'b1;
        im_rdata <= mem_do;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LAT=2 main instance plus a LAT=1 instance.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst;
  logic        im_req, dm_read, dm_write;
  logic [31:0] im_addr, dm_addr, dm_wdata, im_rdata, dm_rdata, mem_di, mem_do;
  logic [3:0]  dm_web, mem_web;
  logic        im_stall, dm_stall, mem_cs;
  logic [13:0] mem_addr;

  logic        im_req_1, dm_read_1, dm_write_1;
  logic [31:0] im_addr_1, dm_addr_1, dm_wdata_1, im_rdata_1, dm_rdata_1, mem_di_1, mem_do_1;
  logic [3:0]  dm_web_1, mem_web_1;
  logic        im_stall_1, dm_stall_1, mem_cs_1;
  logic [13:0] mem_addr_1;

  logic [31:0] mem [0:63];
  logic [31:0] im_q[$];
  logic [31:0] dm_q[$];
  int n_cmp, n_bad;

  mem_arbiter #(.ADDR_W(14), .LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_stall(im_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_web(dm_web),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_cs(mem_cs), .mem_web(mem_web), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  mem_arbiter #(.ADDR_W(14), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .im_req(im_req_1), .im_addr(im_addr_1), .im_rdata(im_rdata_1), .im_stall(im_stall_1),
    .dm_read(dm_read_1), .dm_write(dm_write_1), .dm_addr(dm_addr_1), .dm_web(dm_web_1),
    .dm_wdata(dm_wdata_1), .dm_rdata(dm_rdata_1), .dm_stall(dm_stall_1),
    .mem_cs(mem_cs_1), .mem_web(mem_web_1), .mem_addr(mem_addr_1), .mem_di(mem_di_1),
    .mem_do(mem_do_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: preloaded while reset is high, byte-enabled writes otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
      mem[0]  <= 32'h0000_0297;
      mem[1]  <= 32'h0000_0013;
      mem[2]  <= 32'h0010_0093;
      mem[4]  <= 32'h1234_5678;
      mem[16] <= 32'hDEAD_BEEF;
    end else if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (!mem_web[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_di[8*b +: 8];
    end
  end
  assign mem_do   = mem[mem_addr[5:0]];
  assign mem_do_1 = mem[mem_addr_1[5:0]];

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL reset mem_cs got=%b exp=0", mem_cs); end
    n_cmp++; if (mem_web !== 4'b1111) begin n_bad++; $display("FAIL reset mem_web got=%b exp=1111", mem_web); end
    n_cmp++; if (mem_addr !== 14'd0) begin n_bad++; $display("FAIL reset mem_addr got=%0d exp=0", mem_addr); end
    n_cmp++; if (mem_di !== 32'd0) begin n_bad++; $display("FAIL reset mem_di got=%h exp=0", mem_di); end
    n_cmp++; if (im_rdata !== 32'd0 || dm_rdata !== 32'd0) begin n_bad++; $display("FAIL reset rdata got=%h/%h exp=0/0", im_rdata, dm_rdata); end
    n_cmp++; if (mem_cs_1 !== 1'b0 || mem_web_1 !== 4'b1111) begin n_bad++; $display("FAIL reset lat1 cs/web got=%b/%b exp=0/1111", mem_cs_1, mem_web_1); end
    im_req = 1'b1;
    #1;
    n_cmp++; if (im_stall !== 1'b1) begin n_bad++; $display("FAIL reset comb im_stall got=%b exp=1", im_stall); end
    im_req = 1'b0;
    #1;
    n_cmp++; if (im_stall !== 1'b0 || dm_stall !== 1'b0) begin n_bad++; $display("FAIL reset stalls got=%b/%b exp=0/0", im_stall, dm_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    logic [31:0] exp;
    im_req = 1'b1; im_addr = 32'h0000_0008; im_q.push_back(32'h0010_0093);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      n_cmp++; if (im_stall !== (cyc < 3)) begin n_bad++; $display("FAIL single im_stall cyc=%0d got=%b exp=%b", cyc, im_stall, cyc < 3); end
      n_cmp++; if (mem_cs !== (cyc == 1 || cyc == 2)) begin n_bad++; $display("FAIL single mem_cs cyc=%0d got=%b", cyc, mem_cs); end
      if (cyc == 1 || cyc == 2) begin
        n_cmp++; if (mem_addr !== 14'd2) begin n_bad++; $display("FAIL single mem_addr cyc=%0d got=%0d exp=2", cyc, mem_addr); end
      end
      if (cyc == 3) begin
        exp = im_q.pop_front();
        n_cmp++; if (im_rdata !== exp) begin n_bad++; $display("FAIL single im_rdata got=%h exp=%h", im_rdata, exp); end
      end
      @(posedge clk); #1;
    end
    im_req = 1'b0;
  endtask

  task automatic test_both();
    logic [31:0] exp;
    dm_read = 1'b1; dm_addr = 32'h0000_0040; dm_q.push_back(32'hDEAD_BEEF);
    im_req  = 1'b1; im_addr = 32'h0000_0004; im_q.push_back(32'h0000_0013);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      @(negedge clk);
      n_cmp++; if (dm_stall !== (cyc < 3) || im_stall !== (cyc < 5)) begin n_bad++; $display("FAIL both stalls cyc=%0d got=%b/%b", cyc, dm_stall, im_stall); end
      n_cmp++; if (mem_cs !== (cyc >= 1 && cyc <= 4)) begin n_bad++; $display("FAIL both mem_cs cyc=%0d got=%b", cyc, mem_cs); end
      if (cyc == 1 || cyc == 2) begin
        n_cmp++; if (mem_addr !== 14'd16 || mem_web !== 4'b1111) begin n_bad++; $display("FAIL both dm access cyc=%0d addr=%0d web=%b exp=16/1111", cyc, mem_addr, mem_web); end
      end
      if (cyc == 3 || cyc == 4) begin
        n_cmp++; if (mem_addr !== 14'd1) begin n_bad++; $display("FAIL both im access cyc=%0d addr=%0d exp=1", cyc, mem_addr); end
      end
      if (cyc == 5) begin
        exp = dm_q.pop_front();
        n_cmp++; if (dm_rdata !== exp) begin n_bad++; $display("FAIL both dm_rdata got=%h exp=%h", dm_rdata, exp); end
        exp = im_q.pop_front();
        n_cmp++; if (im_rdata !== exp) begin n_bad++; $display("FAIL both im_rdata got=%h exp=%h", im_rdata, exp); end
      end
      @(posedge clk); #1;
    end
    dm_read = 1'b0; im_req = 1'b0;
  endtask

  task automatic test_write();
    logic [31:0] exp;
    dm_write = 1'b1; dm_addr = 32'h0000_0010; dm_web = 4'b1100; dm_wdata = 32'h0000_BEEF;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      n_cmp++; if (dm_stall !== (cyc < 3)) begin n_bad++; $display("FAIL write dm_stall cyc=%0d got=%b", cyc, dm_stall); end
      if (cyc == 1 || cyc == 2) begin
        n_cmp++; if (mem_cs !== 1'b1 || mem_addr !== 14'd4 || mem_web !== 4'b1100 || mem_di !== 32'h0000_BEEF) begin
          n_bad++; $display("FAIL write access cyc=%0d cs=%b addr=%0d web=%b di=%h", cyc, mem_cs, mem_addr, mem_web, mem_di); end
      end
      if (cyc == 3) begin
        n_cmp++; if (dm_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL write dm_rdata changed got=%h exp=deadbeef", dm_rdata); end
      end
      @(posedge clk); #1;
    end
    dm_write = 1'b0; dm_web = 4'b1111;
    dm_read = 1'b1; dm_q.push_back(32'h1234_BEEF);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        exp = dm_q.pop_front();
        n_cmp++; if (dm_stall !== 1'b0 || dm_rdata !== exp) begin n_bad++; $display("FAIL readback stall=%b got=%h exp=%h", dm_stall, dm_rdata, exp); end
      end
      @(posedge clk); #1;
    end
    dm_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int cs_cycles;
    cs_cycles = 0;
    im_req = 1'b1; im_addr = 32'h0; im_q.push_back(32'h0000_0297);
    for (int cyc = 0; cyc <= 11; cyc++) begin
      if (cyc == 4) begin im_addr = 32'h4; im_q.push_back(32'h0000_0013); end
      if (cyc == 8) begin im_addr = 32'h8; im_q.push_back(32'h0010_0093); end
      @(negedge clk);
      if (mem_cs === 1'b1) cs_cycles++;
      n_cmp++; if (im_stall !== (cyc % 4 != 3)) begin n_bad++; $display("FAIL b2b im_stall cyc=%0d got=%b exp=%b", cyc, im_stall, cyc % 4 != 3); end
      if (cyc % 4 == 3) begin
        exp = im_q.pop_front();
        n_cmp++; if (im_rdata !== exp) begin n_bad++; $display("FAIL b2b im_rdata cyc=%0d got=%h exp=%h", cyc, im_rdata, exp); end
      end
      @(posedge clk); #1;
    end
    im_req = 1'b0;
    n_cmp++; if (cs_cycles != 6) begin n_bad++; $display("FAIL b2b access cycles got=%0d exp=6", cs_cycles); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    dm_read = 1'b1; dm_addr = 32'h0000_0040;
    for (int cyc = 0; cyc <= 2; cyc++) begin
      @(negedge clk);
      if (cyc < 2) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_cs !== 1'b0 || mem_web !== 4'b1111 || mem_addr !== 14'd0) begin n_bad++; $display("FAIL midrst mem got cs=%b web=%b addr=%0d", mem_cs, mem_web, mem_addr); end
    n_cmp++; if (dm_rdata !== 32'd0 || im_rdata !== 32'd0) begin n_bad++; $display("FAIL midrst rdata got=%h/%h exp=0/0", dm_rdata, im_rdata); end
    n_cmp++; if (dm_stall !== 1'b1) begin n_bad++; $display("FAIL midrst dm_stall got=%b exp=1", dm_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    dm_q.push_back(32'hDEAD_BEEF);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      n_cmp++; if (mem_cs !== (cyc == 1 || cyc == 2)) begin n_bad++; $display("FAIL midrst restart mem_cs cyc=%0d got=%b", cyc, mem_cs); end
      if (cyc == 3) begin
        exp = dm_q.pop_front();
        n_cmp++; if (dm_stall !== 1'b0 || dm_rdata !== exp) begin n_bad++; $display("FAIL midrst result stall=%b got=%h exp=%h", dm_stall, dm_rdata, exp); end
      end
      @(posedge clk); #1;
    end
    dm_read = 1'b0;
  endtask

  task automatic test_lat1();
    logic [31:0] exp;
    dm_read_1 = 1'b1; dm_addr_1 = 32'h0000_0040; dm_q.push_back(32'hDEAD_BEEF);
    im_req_1  = 1'b1; im_addr_1 = 32'h0000_0004; im_q.push_back(32'h0000_0013);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      n_cmp++; if (mem_cs_1 !== (cyc == 1 || cyc == 2)) begin n_bad++; $display("FAIL lat1 mem_cs cyc=%0d got=%b", cyc, mem_cs_1); end
      if (cyc == 1) begin
        n_cmp++; if (mem_addr_1 !== 14'd16) begin n_bad++; $display("FAIL lat1 dm addr got=%0d exp=16", mem_addr_1); end
      end
      if (cyc == 2) begin
        n_cmp++; if (mem_addr_1 !== 14'd1) begin n_bad++; $display("FAIL lat1 im addr got=%0d exp=1", mem_addr_1); end
      end
      n_cmp++; if (im_stall_1 !== (cyc < 3) || dm_stall_1 !== (cyc < 2)) begin n_bad++; $display("FAIL lat1 stalls cyc=%0d got=%b/%b", cyc, im_stall_1, dm_stall_1); end
      if (cyc == 3) begin
        exp = dm_q.pop_front();
        n_cmp++; if (dm_rdata_1 !== exp) begin n_bad++; $display("FAIL lat1 dm_rdata got=%h exp=%h", dm_rdata_1, exp); end
        exp = im_q.pop_front();
        n_cmp++; if (im_rdata_1 !== exp) begin n_bad++; $display("FAIL lat1 im_rdata got=%h exp=%h", im_rdata_1, exp); end
      end
      @(posedge clk); #1;
    end
    dm_read_1 = 1'b0; im_req_1 = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    im_req = 1'b0; im_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_web = 4'b1111; dm_wdata = '0;
    im_req_1 = 1'b0; im_addr_1 = '0; dm_read_1 = 1'b0; dm_write_1 = 1'b0;
    dm_addr_1 = '0; dm_web_1 = 4'b1111; dm_wdata_1 = '0;
    test_reset();
    test_single_fetch();
    @(posedge clk); #1;
    test_both();
    @(posedge clk); #1;
    test_write();
    @(posedge clk); #1;
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_mid();
    @(posedge clk); #1;
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
